// File: rtl/forward_stall_unit.sv
// Operand-forwarding select, load-use hazard detection and multi-cycle unit tracking.
// Define FWD_MC_EN to build the multi-cycle FSM; otherwise only the load-use stall exists.
module forward_stall_unit #(
   parameter int REG_AW  = 5,
   parameter int NUM_FWD = 2,
   parameter int MC_LAT  = 4,
   localparam int FSEL_W = $clog2(NUM_FWD + 1)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_FWD-1:0]        fwd_we_i,
   input  logic [NUM_FWD*REG_AW-1:0] fwd_rd_i,
   input  logic [REG_AW-1:0]         ex_rs1_i,
   input  logic [REG_AW-1:0]         ex_rs2_i,
   input  logic [REG_AW-1:0]         id_rs1_i,
   input  logic [REG_AW-1:0]         id_rs2_i,
   input  logic                      id_mc_i,
   input  logic                      ex_memread_i,
   input  logic [REG_AW-1:0]         ex_rd_i,
   input  logic                      mc_issue_i,
   input  logic [REG_AW-1:0]         mc_rd_i,
   output logic [FSEL_W-1:0]         fwd_a_o,
   output logic [FSEL_W-1:0]         fwd_b_o,
   output logic                      stall_o,
   output logic                      mc_busy_o,
   output logic                      mc_wb_o,
   output logic [REG_AW-1:0]         mc_wb_rd_o
);

   logic load_use_stall;
   logic mc_stall;

   // Walk oldest to youngest so the youngest matching source overwrites the others.
   always_comb begin
      fwd_a_o = '0;
      fwd_b_o = '0;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         if (fwd_we_i[k] && (fwd_rd_i[k*REG_AW +: REG_AW] != '0)) begin
            if (fwd_rd_i[k*REG_AW +: REG_AW] == ex_rs1_i) fwd_a_o = FSEL_W'(k + 1);
            if (fwd_rd_i[k*REG_AW +: REG_AW] == ex_rs2_i) fwd_b_o = FSEL_W'(k + 1);
         end
      end
   end

   assign load_use_stall = ex_memread_i && (ex_rd_i != '0) &&
                           ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

`ifdef FWD_MC_EN
   localparam int CNT_W = (MC_LAT > 2) ? $clog2(MC_LAT - 1) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} mc_state_e;

   mc_state_e           state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [REG_AW-1:0]   mc_rd_q;
   logic [REG_AW-1:0]   mc_wb_rd_q;
   logic                mc_wb_q;
   logic                mc_busy_q;
   logic                raw_stall;
   logic                struct_stall;

   // DONE accepts a new issue in the same cycle the old result is written back.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         mc_rd_q    <= '0;
         mc_wb_rd_q <= '0;
         mc_wb_q    <= 1'b0;
         mc_busy_q  <= 1'b0;
      end else begin
         mc_wb_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (mc_issue_i) begin
                  state_q   <= BUSY;
                  cnt_q     <= CNT_W'(MC_LAT - 2);
                  mc_rd_q   <= mc_rd_i;
                  mc_busy_q <= 1'b1;
               end else begin
                  state_q   <= IDLE;
                  mc_busy_q <= 1'b0;
               end
            end
            BUSY: begin
               if (cnt_q == '0) begin
                  state_q    <= DONE;
                  mc_wb_q    <= 1'b1;
                  mc_wb_rd_q <= mc_rd_q;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
               state_q   <= IDLE;
               mc_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign raw_stall    = (state_q != IDLE) && (mc_rd_q != '0) &&
                         ((mc_rd_q == id_rs1_i) || (mc_rd_q == id_rs2_i));
   assign struct_stall = id_mc_i && (state_q == BUSY);
   assign mc_stall     = raw_stall || struct_stall;

   assign mc_busy_o  = mc_busy_q;
   assign mc_wb_o    = mc_wb_q;
   assign mc_wb_rd_o = mc_wb_rd_q;
`else
   logic unused_mc;
   assign unused_mc  = ^{clk_i, rst_i, id_mc_i, mc_issue_i, mc_rd_i, (MC_LAT > 1)};
   assign mc_stall   = 1'b0;
   assign mc_busy_o  = 1'b0;
   assign mc_wb_o    = 1'b0;
   assign mc_wb_rd_o = '0;
`endif

   assign stall_o = load_use_stall || mc_stall;

endmodule

// File: doc/forward_stall_unit.md
FORWARD_STALL_UNIT -- requirements
Module: forward_stall_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter NUM_FWD, default 2 (range 1..7), forwarding sources; index 0 youngest (MEM), index NUM_FWD-1 oldest.
REQ-003 SHALL have parameter MC_LAT, default 4 (min 2), multi-cycle unit latency in cycles.
REQ-004 SHALL derive localparam FSEL_W = $clog2(NUM_FWD+1).
REQ-005 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports fwd_we_i  input  NUM_FWD  and  fwd_rd_i  input  NUM_FWD*REG_AW: per-source write enable and destination; source k occupies bits [k*REG_AW +: REG_AW].
REQ-008 SHALL have ports ex_rs1_i, ex_rs2_i  input  REG_AW: EX-stage sources.
REQ-009 SHALL have ports id_rs1_i, id_rs2_i  input  REG_AW  and  id_mc_i  input  1: ID-stage sources; ID instruction is multi-cycle.
REQ-010 SHALL have ports ex_memread_i  input  1  and  ex_rd_i  input  REG_AW: EX load and its destination.
REQ-011 SHALL have ports mc_issue_i  input  1  and  mc_rd_i  input  REG_AW: multi-cycle op leaving EX this cycle.
REQ-012 SHALL have ports fwd_a_o, fwd_b_o  output  FSEL_W: 0 = register file, k = source k-1.
REQ-013 SHALL have ports stall_o  output  1  (hold PC and IF/ID, bubble ID/EX), mc_busy_o  output  1, mc_wb_o  output  1, mc_wb_rd_o  output  REG_AW.

Function
REQ-014 fwd_a_o SHALL be k+1 for the lowest k with fwd_we_i[k], rd_k != 0, rd_k == ex_rs1_i; else 0 (combinational, zero latency). fwd_b_o likewise with ex_rs2_i.
REQ-015 Address 0 SHALL never match for forwarding or stall.
REQ-016 Load-use stall: ex_memread_i, ex_rd_i != 0, ex_rd_i equal to id_rs1_i or id_rs2_i.
REQ-017 Multi-cycle FSM SHALL have states IDLE, BUSY, DONE, plus a counter and a latched destination mc_rd_q.
REQ-018 IDLE or DONE with mc_issue_i: next BUSY, counter = MC_LAT-2, mc_rd_q = mc_rd_i; DONE without issue -> IDLE.
REQ-019 BUSY: counter decrements each cycle; at counter 0 -> DONE; mc_issue_i in BUSY SHALL be ignored.
REQ-020 Latency: issue sampled in cycle T -> mc_wb_o = 1 exactly in cycle T+MC_LAT, one cycle wide, mc_wb_rd_o = mc_rd_q.
REQ-021 mc_busy_o SHALL be 1 in BUSY and DONE.
REQ-022 RAW stall: state != IDLE, mc_rd_q != 0, mc_rd_q equal to id_rs1_i or id_rs2_i; asserted through DONE, released the following cycle.
REQ-023 Structural stall: id_mc_i in BUSY.
REQ-024 stall_o SHALL be the OR of REQ-016, REQ-022 and REQ-023, combinational.
REQ-025 Back-to-back issue in DONE SHALL produce mc_wb_o for the old op in that cycle and restart timing for the new op.

Reset
REQ-026 rst_i low SHALL immediately force IDLE, counter 0, mc_rd_q 0, mc_wb_o 0, mc_wb_rd_o 0, mc_busy_o 0; an in-flight op SHALL be discarded with no mc_wb_o.
REQ-027 fwd_a_o, fwd_b_o and stall_o SHALL remain combinational functions of inputs during reset, with FSM terms at reset values.

Configuration
REQ-028 Macro FWD_MC_EN SHALL gate the multi-cycle FSM: defined -> REQ-017..REQ-025 active; undefined -> no FSM state, mc_* inputs and id_mc_i ignored, mc_busy_o = mc_wb_o = 0, mc_wb_rd_o = 0, stall_o = load-use term only.

Verification
REQ-029 NUM_FWD=2; fwd_we_i=2'b11, both rd = 5, ex_rs1_i=5 -> fwd_a_o = 1 (youngest wins).
REQ-030 fwd_we_i=2'b10, rd1 = 0, ex_rs2_i=0 -> fwd_b_o = 0.
REQ-031 ex_memread_i=1, ex_rd_i=7, id_rs2_i=7 -> stall_o = 1; ex_rd_i=0 -> stall_o = 0.
REQ-032 FWD_MC_EN, MC_LAT=4, mc_issue_i with mc_rd_i=9 in cycle 0 -> mc_wb_o = 1 only in cycle 4, mc_wb_rd_o = 9; id_rs1_i=9 -> stall_o = 1 in cycles 1-4, 0 in cycle 5.
REQ-033 Issue rd=3 in cycle 0; issue rd=4 in cycle 4 (DONE) -> mc_wb_o in cycle 4 (rd 3) and cycle 8 (rd 4).
REQ-034 Issue in cycle 0; rst_i low in cycle 2, high in cycle 3 -> mc_wb_o never asserts; mc_busy_o = 0 from cycle 2.
